axi_lite_req_master: RTL and testbench
======================================

# axi_lite_req_master

Single-outstanding AXI4 master that converts a simple valid/ready CPU-style request port into single-beat 32-bit AXI4 transactions. It sits directly upstream of `axi_mem_wrapper` (or any AXI slave on the same `s_axi_mosi_t`/`s_axi_miso_t` bus) and lets simple cores, loaders and testbenches access the RAM without building AXI handshakes themselves.

## Interface
Parameters:
- `ID_VAL`, 0: value driven on `awid`/`arid`; the response ID is not checked.
- `PROT_VAL`, 3'b000: value driven on `awprot`/`arprot`.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address. Bits [1:0] are forced to 0 on the bus.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  write byte strobes.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  read data; 0 for writes.
- `resp_err`  out  1  SLVERR/DECERR or protocol error.
- `axi_mosi`  out  `s_axi_mosi_t`  AXI master outputs.
- `axi_miso`  in  `s_axi_miso_t`  AXI slave responses.

## Operation
- **FSM states:** IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- **IDLE**
  - `req_ready=1`.
  - On accept, register the address, data, strobe and direction.
  - Go to WR_ADDR_DATA if `req_we`, else RD_ADDR.
- **WR_ADDR_DATA**
  - `awvalid` and `wvalid` both assert on entry.
  - Each deasserts independently the cycle after its own handshake (`awvalid&&awready`, `wvalid&&wready`). Two done flags track this.
  - Handshakes may happen in either order or in the same cycle.
  - Go to WR_RESP once both are done.
- **WR_RESP**
  - `bready=1`.
  - On `bvalid`, latch `err = bresp[1]` and go to RESP.
- **RD_ADDR**
  - `arvalid=1` until `arready`, then go to RD_DATA.
- **RD_DATA**
  - `rready=1`.
  - On `rvalid`, latch `rdata` and `err = rresp[1] | ~rlast`, then go to RESP.
- **RESP**
  - `resp_valid=1` for exactly one cycle, with `resp_rdata` and `resp_err` valid.
  - Return to IDLE.
  - No backpressure on the response side: the consumer must take it.
- **Fixed AXI fields:**
  - `awlen/arlen=0`, `awsize/arsize=3'b010`, `awburst/arburst=2'b01` (INCR).
  - `awlock/arlock=0`, `awcache/arcache=4'b0000`, `wlast=1` whenever `wvalid`.
  - All fields not listed here are driven 0.
- **Address/data stability:**
  - AXI address and data outputs come only from the registered request.
  - They stay stable while the matching valid is high. Changes on `req_*` after acceptance have no effect.
- **Reset (also mid-transaction):**
  - All valid/ready outputs go to 0, the FSM goes to IDLE, and `resp_rdata`/`resp_err` go to 0.
  - Any in-flight AXI transaction is abandoned. The downstream slave must be reset with the same `rst`.
  - `req_ready` reads 1 from the first cycle after reset deasserts.

## Timing
- **Reset values:** every output is 0 during reset. This includes `req_ready`, all AXI valids and readies, and `resp_*`.
- **Valid timing:** AXI valids are registered. They are high the cycle after request acceptance.
- **Minimum write latency:**
  - Accept in cycle 0; AW/W handshake in cycle 1.
  - `bvalid` sampled in cycle ≥2, so `resp_valid` is at cycle ≥3.
- **Minimum read latency:** accept in cycle 0, AR in cycle 1, R in cycle ≥2, `resp_valid` at cycle ≥3.
- **Response-to-request turnaround:** `req_ready` returns in the cycle after `resp_valid`. The next request can be accepted there, with no dead cycle beyond RESP.
- **Strict ordering:** one transaction in flight at any time.
- **Combinational paths:** none from `axi_miso` to `axi_mosi` or to `req_ready`. The `ready` signals are state-decoded only.

## Test plan
- **Write then read:**
  - Stimulus: write 0xDEADBEEF to 0x10 (`wstrb` 0xF), then read 0x10.
  - Required: write gives `resp_err=0`; read gives `resp_rdata=0xDEADBEEF`.
  - Check AXI fields: `awlen=0`, `awsize=2`, `awburst=1`, `wlast=1`.
- **Byte strobes:**
  - Stimulus: write 0x11223344 to 0x20 with `wstrb` 0xF, then write 0xAABBCCDD with `wstrb` 0x5, then read.
  - Required: read returns 0x11BB33DD.
- **Split AW/W handshakes:**
  - Stimulus: slave model holds `awready` low for 3 cycles while taking W first. Repeat with the reverse order.
  - Required: exactly one handshake on each channel and a single `resp_valid`.
  - Required: `wvalid` drops after its handshake while `awvalid` stays high.
- **Error path:**
  - Stimulus: slave returns `bresp=2'b10` on a write, then `rresp=2'b11` on a read, then `rlast=0` with OKAY.
  - Required: `resp_err=1` in all three cases.
- **Unaligned address and request stability:**
  - Stimulus: request address 0x1003.
  - Required: `awaddr`/`araddr` = 0x1000.
  - Stimulus: change `req_addr` after acceptance with `arready` held low 4 cycles.
  - Required: `araddr` stays 0x1000 throughout.
- **Reset mid-transaction:**
  - Stimulus: assert `rst` for 1 cycle while in WR_ADDR_DATA with `awvalid` high.
  - Required: next cycle all valids are 0 and no `resp_valid` occurs.
  - Required: after release, `req_ready=1` and a subsequent read of a freshly written location completes correctly.

Source files
------------

// File: rtl/axi_lite_req_master.sv
// Single-outstanding AXI4 master driven by a simple valid/ready request port.
// Issues one single-beat 32-bit transaction at a time and pulses a response.
package axi_lite_pkg;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

endpackage

module axi_lite_req_master
    import axi_lite_pkg::*;
#(
    parameter logic [3:0] ID_VAL   = 4'd0,
    parameter logic [2:0] PROT_VAL = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output s_axi_mosi_t axi_mosi,
    input  s_axi_miso_t axi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_hs, w_hs;
    s_axi_mosi_t mosi;

    logic unused_in;
    assign unused_in = ^{axi_miso.bid, axi_miso.rid,
                         axi_miso.bresp[0], axi_miso.rresp[0],
                         req_addr[1:0]};

    // State, latched request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state logic and state-decoded AXI outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;

        mosi         = '0;
        mosi.awid    = ID_VAL;
        mosi.awaddr  = addr_q;
        mosi.awsize  = 3'b010;
        mosi.awburst = 2'b01;
        mosi.awprot  = PROT_VAL;
        mosi.wdata   = wdata_q;
        mosi.wstrb   = wstrb_q;
        mosi.arid    = ID_VAL;
        mosi.araddr  = addr_q;
        mosi.arsize  = 3'b010;
        mosi.arburst = 2'b01;
        mosi.arprot  = PROT_VAL;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = {req_addr[31:2], 2'b00};
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                mosi.awvalid = ~aw_done_q;
                mosi.wvalid  = ~w_done_q;
                mosi.wlast   = ~w_done_q;
                aw_hs = mosi.awvalid & axi_miso.awready;
                w_hs  = mosi.wvalid & axi_miso.wready;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                mosi.bready = 1'b1;
                if (axi_miso.bvalid) begin
                    err_d   = axi_miso.bresp[1];
                    state_d = RESP;
                end
            end
            RD_ADDR: begin
                mosi.arvalid = 1'b1;
                if (axi_miso.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                mosi.rready = 1'b1;
                if (axi_miso.rvalid) begin
                    rdata_d = axi_miso.rdata;
                    err_d   = axi_miso.rresp[1] | ~axi_miso.rlast;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Everything reads as zero while reset is held
    assign axi_mosi   = rst ? '0 : mosi;
    assign req_ready  = ~rst & (state_q == IDLE);
    assign resp_valid = ~rst & (state_q == RESP);
    assign resp_rdata = rst ? '0 : rdata_q;
    assign resp_err   = ~rst & err_q;

endmodule

// File: tb/tb_axi_lite_req_master.sv
// Directed bench for axi_lite_req_master.
// Includes a small AXI slave RAM with stall and error knobs.
module tb_axi_lite_req_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_lite_req_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi_mosi   (mosi),
        .axi_miso   (miso)
    );

    // Slave knobs
    int         aw_wait = 0;
    int         w_wait = 0;
    int         ar_wait = 0;
    logic [1:0] bresp_k = 2'b00;
    logic [1:0] rresp_k = 2'b00;
    logic       rlast_k = 1'b1;

    // Slave state
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got, bv, rv, rl;
    logic [31:0] aw_a, w_d, rd;
    logic [3:0]  w_s;
    logic [1:0]  rr;
    logic [31:0] mem [0:4095];
    logic [31:0] s_wa, s_wd;
    logic [3:0]  s_ws;

    assign s_wa = aw_got ? aw_a : mosi.awaddr;
    assign s_wd = w_got ? w_d : mosi.wdata;
    assign s_ws = w_got ? w_s : mosi.wstrb;

    // Slave ready/response drive
    always_comb begin
        miso         = '0;
        miso.awready = mosi.awvalid && !aw_got && (aw_cnt >= aw_wait);
        miso.wready  = mosi.wvalid && !w_got && (w_cnt >= w_wait);
        miso.bvalid  = bv;
        miso.bresp   = bresp_k;
        miso.arready = mosi.arvalid && !rv && (ar_cnt >= ar_wait);
        miso.rvalid  = rv;
        miso.rdata   = rd;
        miso.rresp   = rr;
        miso.rlast   = rl;
    end

    // Slave RAM behaviour
    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
            ar_cnt <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bv     <= 1'b0;
            rv     <= 1'b0;
        end else begin
            if (mosi.awvalid && !miso.awready) aw_cnt <= aw_cnt + 1;
            if (miso.awready) begin
                aw_got <= 1'b1;
                aw_a   <= mosi.awaddr;
                aw_cnt <= 0;
            end
            if (mosi.wvalid && !miso.wready) w_cnt <= w_cnt + 1;
            if (miso.wready) begin
                w_got <= 1'b1;
                w_d   <= mosi.wdata;
                w_s   <= mosi.wstrb;
                w_cnt <= 0;
            end
            if ((aw_got || miso.awready) && (w_got || miso.wready)) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_ws[b]) mem[s_wa[13:2]][8*b +: 8] <= s_wd[8*b +: 8];
                end
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bv     <= 1'b1;
            end
            if (bv && mosi.bready) bv <= 1'b0;
            if (mosi.arvalid && !miso.arready) ar_cnt <= ar_cnt + 1;
            if (miso.arready) begin
                rd     <= mem[mosi.araddr[13:2]];
                rr     <= rresp_k;
                rl     <= rlast_k;
                rv     <= 1'b1;
                ar_cnt <= 0;
            end
            if (rv && mosi.rready) rv <= 1'b0;
        end
    end

    // Bus monitor counters and captures
    int          n_aw = 0, n_w = 0, n_resp = 0;
    int          n_aw_only = 0, n_w_only = 0, n_ar_bad = 0;
    logic [31:0] exp_araddr = '0;
    logic [31:0] last_awaddr = '0, last_araddr = '0;
    logic [7:0]  last_awlen = 8'hFF;
    logic [2:0]  last_awsize = '0;
    logic [1:0]  last_awburst = '0;
    logic        last_wlast = 1'b0;

    always @(negedge clk) begin
        if (mosi.awvalid && miso.awready) begin
            n_aw         <= n_aw + 1;
            last_awaddr  <= mosi.awaddr;
            last_awlen   <= mosi.awlen;
            last_awsize  <= mosi.awsize;
            last_awburst <= mosi.awburst;
        end
        if (mosi.wvalid && miso.wready) begin
            n_w        <= n_w + 1;
            last_wlast <= mosi.wlast;
        end
        if (mosi.arvalid && miso.arready) last_araddr <= mosi.araddr;
        if (mosi.arvalid && mosi.araddr !== exp_araddr) n_ar_bad <= n_ar_bad + 1;
        if (mosi.awvalid && !mosi.wvalid) n_aw_only <= n_aw_only + 1;
        if (mosi.wvalid && !mosi.awvalid) n_w_only <= n_w_only + 1;
        if (resp_valid) n_resp <= n_resp + 1;
    end

    task automatic do_req(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout addr=%h ready=%b want=1", a, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_F00D;
        req_wstrb = 4'h0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL resp_timeout addr=%h valid=%b want=1", a, resp_valid);
        end
        rdata = resp_rdata;
        err   = resp_err;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_req_ready got=%b want=0", req_ready);
        end
        total++;
        if (mosi !== '0) begin
            bad++;
            $display("FAIL rst_mosi got=%h want=0", mosi);
        end
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
            bad++;
            $display("FAIL rst_resp got=%b/%b/%h want=0/0/0",
                     resp_valid, resp_err, resp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdata, err, lat);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL wr_err got=%b want=0", err);
        end
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL wr_rdata got=%h want=0", rdata);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL wr_latency got=%0d want=3", lat);
        end
        total++;
        if ({last_awlen, last_awsize, last_awburst, last_wlast} !==
            {8'd0, 3'd2, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL aw_fields got=%h/%h/%h/%b want=0/2/1/1",
                     last_awlen, last_awsize, last_awburst, last_wlast);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rdata, err, lat);
        total++;
        if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            bad++;
            $display("FAIL rd_data got=%h/%b want=deadbeef/0", rdata, err);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL rd_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rdata, err, lat);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rdata, err, lat);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat);
        total++;
        if (rdata !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL strobe_merge got=%h want=11bb33dd", rdata);
        end
    endtask

    task automatic test_split_aw_w();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          aw0, w0, r0, ao0, wo0;
        aw_wait = 3;
        w_wait  = 0;
        aw0 = n_aw; w0 = n_w; r0 = n_resp; ao0 = n_aw_only; wo0 = n_w_only;
        do_req(1'b1, 32'h30, 32'h01020304, 4'hF, rdata, err, lat);
        @(negedge clk); #1;
        total++;
        if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_resp - r0 !== 1) begin
            bad++;
            $display("FAIL split_w_first_counts got=%0d/%0d/%0d want=1/1/1",
                     n_aw - aw0, n_w - w0, n_resp - r0);
        end
        total++;
        if (n_aw_only - ao0 !== 3 || n_w_only - wo0 !== 0) begin
            bad++;
            $display("FAIL split_aw_hold got=%0d/%0d want=3/0",
                     n_aw_only - ao0, n_w_only - wo0);
        end
        aw_wait = 0;
        w_wait  = 3;
        aw0 = n_aw; w0 = n_w; r0 = n_resp; ao0 = n_aw_only; wo0 = n_w_only;
        do_req(1'b1, 32'h30, 32'h0A0B0C0D, 4'hF, rdata, err, lat);
        @(negedge clk); #1;
        total++;
        if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_resp - r0 !== 1) begin
            bad++;
            $display("FAIL split_aw_first_counts got=%0d/%0d/%0d want=1/1/1",
                     n_aw - aw0, n_w - w0, n_resp - r0);
        end
        total++;
        if (n_w_only - wo0 !== 3 || n_aw_only - ao0 !== 0) begin
            bad++;
            $display("FAIL split_w_hold got=%0d/%0d want=3/0",
                     n_w_only - wo0, n_aw_only - ao0);
        end
        w_wait = 0;
        do_req(1'b0, 32'h30, 32'h0, 4'h0, rdata, err, lat);
        total++;
        if (rdata !== 32'h0A0B0C0D || err !== 1'b0) begin
            bad++;
            $display("FAIL split_readback got=%h/%b want=0a0b0c0d/0", rdata, err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        bresp_k = 2'b10;
        do_req(1'b1, 32'h40, 32'h12345678, 4'hF, rdata, err, lat);
        bresp_k = 2'b00;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_bresp got=%b want=1", err);
        end
        rresp_k = 2'b11;
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rdata, err, lat);
        rresp_k = 2'b00;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_rresp got=%b want=1", err);
        end
        rlast_k = 1'b0;
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rdata, err, lat);
        rlast_k = 1'b1;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_rlast got=%b want=1", err);
        end
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rdata, err, lat);
        total++;
        if (err !== 1'b0 || rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL ok_after_err got=%b/%h want=0/12345678", err, rdata);
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          b0;
        do_req(1'b1, 32'h1003, 32'hCAFE0001, 4'hF, rdata, err, lat);
        total++;
        if (last_awaddr !== 32'h1000) begin
            bad++;
            $display("FAIL awaddr_align got=%h want=00001000", last_awaddr);
        end
        exp_araddr = 32'h1000;
        ar_wait = 4;
        b0 = n_ar_bad;
        do_req(1'b0, 32'h1003, 32'h0, 4'h0, rdata, err, lat);
        ar_wait = 0;
        total++;
        if (last_araddr !== 32'h1000 || n_ar_bad - b0 !== 0) begin
            bad++;
            $display("FAIL araddr_stable got=%h/%0d want=00001000/0",
                     last_araddr, n_ar_bad - b0);
        end
        total++;
        if (rdata !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL unaligned_rd got=%h want=cafe0001", rdata);
        end
        total++;
        if (lat !== 7) begin
            bad++;
            $display("FAIL ar_stall_latency got=%0d want=7", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rdata, err, lat);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL turnaround_ready got=%b want=1", req_ready);
        end
        do_req(1'b1, 32'h50, 32'h55AA55AA, 4'hF, rdata, err, lat);
        total++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wr_resp got=%h/%b want=0/0", rdata, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          r0;
        aw_wait = 5;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h60;
        req_wdata = 32'hFFFF0000;
        req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (mosi.awvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_awvalid got=%b want=1", mosi.awvalid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        r0 = n_resp;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({mosi.awvalid, mosi.wvalid, mosi.arvalid,
             mosi.bready, mosi.rready, resp_valid} !== 6'b0) begin
            bad++;
            $display("FAIL mid_rst_valids got=%b%b%b%b%b%b want=000000",
                     mosi.awvalid, mosi.wvalid, mosi.arvalid,
                     mosi.bready, mosi.rready, resp_valid);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst_ready got=%b want=1", req_ready);
        end
        aw_wait = 0;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (n_resp !== r0) begin
            bad++;
            $display("FAIL mid_rst_no_resp got=%0d want=0", n_resp - r0);
        end
        do_req(1'b1, 32'h70, 32'h5A5A1234, 4'hF, rdata, err, lat);
        do_req(1'b0, 32'h70, 32'h0, 4'h0, rdata, err, lat);
        total++;
        if (rdata !== 32'h5A5A1234 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_readback got=%h/%b want=5a5a1234/0", rdata, err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_split_aw_w();
        test_errors();
        test_unaligned();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
